// File: rtl/imem_arbiter.sv
// imem_arbiter
//
// Shares one instruction memory port between two masters using a common
// req/gnt/rvalid handshake. Master 0 is the core instruction fetch, master 1
// is a debug/trace reader. Only one transaction is in flight at a time.
// Simultaneous requests are resolved round-robin. An optional watchdog
// aborts a transaction that waits too long for gnt or rvalid.
//
// Parameters:
//   ADDR_WIDTH      byte address width on all ports
//   DATA_WIDTH      read data width
//   TIMEOUT_CYCLES  cycles allowed in WAIT_GNT or WAIT_RVALID before the
//                   transaction is aborted; 0 disables the watchdog
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   m0_req_i, m0_addr_i        master 0 request and byte address
//   m0_gnt_o, m0_rvalid_o      master 0 grant and read-valid pulses
//   m0_err_o                   master 0 watchdog abort pulse
//   m0_rdata_o                 master 0 read data (broadcast)
//   m1_*                       same set for master 1
//   mem_req_o, mem_addr_o      request and address towards memory
//   mem_gnt_i, mem_rvalid_i    memory grant and read-valid
//   mem_rdata_i                memory read data
//   busy_o                     high whenever a transaction is in progress

module imem_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic                  m0_err_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic                  m1_err_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  busy_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CNT_LAST_INT = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_INT);
    localparam logic WDOG_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    sel_q, sel_d;
    logic                    last_sel_q, last_sel_d;
    logic [CNT_W-1:0]        counter_q, counter_d;
    logic                    mem_req_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;

    logic                    arb_any;
    logic                    winner;
    logic                    timeout_now;
    logic                    gnt_seen;
    logic                    rvalid_seen;
    logic                    abort;

    // Round-robin choice: a lone requester always wins; on a tie the master
    // that was not served last goes first.
    always_comb begin
        arb_any = m0_req_i | m1_req_i;
        winner  = 1'b0;
        if (m0_req_i && m1_req_i) begin
            winner = ~last_sel_q;
        end else begin
            winner = m1_req_i;
        end
    end

    // Handshake events only count in the state that is waiting for them, so
    // a stale-high rvalid during WAIT_GNT is ignored. A same-cycle event
    // beats the watchdog.
    always_comb begin
        timeout_now = WDOG_EN && (counter_q == CNT_LAST);
        gnt_seen    = (state_q == WAIT_GNT) && mem_gnt_i;
        rvalid_seen = (state_q == WAIT_RVALID) && mem_rvalid_i;
        abort       = timeout_now &&
                      (((state_q == WAIT_GNT) && !mem_gnt_i) ||
                       ((state_q == WAIT_RVALID) && !mem_rvalid_i));
    end

    // Next-state logic for the transaction FSM, the memory request/address
    // registers, the fairness pointer and the watchdog counter.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        counter_d  = counter_q;
        mem_req_d  = mem_req_o;
        mem_addr_d = mem_addr_o;

        case (state_q)
            IDLE: begin
                counter_d = '0;
                mem_req_d = 1'b0;
                if (arb_any) begin
                    state_d    = WAIT_GNT;
                    sel_d      = winner;
                    last_sel_d = winner;
                    mem_addr_d = winner ? m1_addr_i : m0_addr_i;
                    mem_req_d  = 1'b1;
                end
            end

            WAIT_GNT: begin
                if (gnt_seen) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT_RVALID;
                    counter_d = '0;
                end else if (abort) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    counter_d = '0;
                end else if (WDOG_EN) begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end

            WAIT_RVALID: begin
                if (rvalid_seen || abort) begin
                    state_d   = IDLE;
                    counter_d = '0;
                end else if (WDOG_EN) begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                counter_d = '0;
            end
        endcase
    end

    // State registers. Reset drops the memory request at once; whatever was
    // in flight is lost and the masters are re-arbitrated afterwards with
    // master 0 favoured on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            last_sel_q <= 1'b1;
            counter_q  <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
            counter_q  <= counter_d;
            mem_req_o  <= mem_req_d;
            mem_addr_o <= mem_addr_d;
        end
    end

    // Master-facing pulses pass the memory handshake straight through to the
    // selected master only; read data is simply broadcast to both.
    assign m0_gnt_o    = gnt_seen    & ~sel_q;
    assign m1_gnt_o    = gnt_seen    &  sel_q;
    assign m0_rvalid_o = rvalid_seen & ~sel_q;
    assign m1_rvalid_o = rvalid_seen &  sel_q;
    assign m0_err_o    = abort       & ~sel_q;
    assign m1_err_o    = abort       &  sel_q;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter
//
// Directed testbench for imem_arbiter. A small memory responder answers the
// arbiter (gnt one cycle after it samples req, rvalid one cycle after gnt,
// optionally holding rvalid high). A transaction-level reference model
// predicts every master/memory output each cycle, and directed scenarios add
// literal expectations at specific cycles.

module tb_imem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk;
    logic          rst_n;
    logic          m0_req_i, m1_req_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic          m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic          m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem_array [256];
    bit            gnt_enable;
    bit            sticky;

    imem_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_i     (m0_req_i),
        .m0_addr_i    (m0_addr_i),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_err_o     (m0_err_o),
        .m0_rdata_o   (m0_rdata_o),
        .m1_req_i     (m1_req_i),
        .m1_addr_i    (m1_addr_i),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_err_o     (m1_err_o),
        .m1_rdata_o   (m1_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h",
                     name, $time, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s at t=%0t: wait bound expired", name, $time);
    endtask

    task automatic applyStimulus(input logic r0, input logic [AW-1:0] a0,
                                 input logic r1, input logic [AW-1:0] a1);
        m0_req_i  = r0;
        m0_addr_i = a0;
        m1_req_i  = r1;
        m1_addr_i = a1;
    endtask

    // Memory responder: samples the arbiter at the rising edge and answers
    // one time unit later. gnt follows a sampled req (one beat per request),
    // rvalid and data follow a sampled gnt; with sticky set rvalid stays high.
    logic          rsp_req_s, rsp_gnt_s;
    logic [AW-1:0] rsp_addr_s;
    always @(posedge clk) begin
        rsp_req_s  = mem_req_o;
        rsp_gnt_s  = mem_gnt_i;
        rsp_addr_s = mem_addr_o;
        #1;
        if (!rst_n) begin
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
        end else begin
            mem_gnt_i = gnt_enable && rsp_req_s && !rsp_gnt_s;
            if (rsp_gnt_s) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_array[rsp_addr_s];
            end else if (!sticky) begin
                mem_rvalid_i = 1'b0;
            end
        end
    end

    // Reference model at transaction level: one optional open transaction
    // (owner, address, whether it has been granted, how long it has waited)
    // plus the identity of the most recently chosen master.
    bit            mdl_active;
    bit            mdl_granted;
    bit            mdl_owner;
    bit            mdl_last;
    logic [AW-1:0] mdl_addr;
    int            mdl_age;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_active  <= 1'b0;
            mdl_granted <= 1'b0;
            mdl_owner   <= 1'b0;
            mdl_last    <= 1'b1;
            mdl_addr    <= '0;
            mdl_age     <= 0;
        end else if (!mdl_active) begin
            if (m0_req_i || m1_req_i) begin
                mdl_active  <= 1'b1;
                mdl_granted <= 1'b0;
                mdl_age     <= 0;
                mdl_owner   <= (m0_req_i && m1_req_i) ? !mdl_last : m1_req_i;
                mdl_last    <= (m0_req_i && m1_req_i) ? !mdl_last : m1_req_i;
                mdl_addr    <= ((m0_req_i && m1_req_i) ? !mdl_last : m1_req_i)
                               ? m1_addr_i : m0_addr_i;
            end
        end else if (mdl_granted ? mem_rvalid_i : mem_gnt_i) begin
            if (mdl_granted) begin
                mdl_active <= 1'b0;
            end else begin
                mdl_granted <= 1'b1;
                mdl_age     <= 0;
            end
        end else if ((TO > 0) && (mdl_age == TO - 1)) begin
            mdl_active <= 1'b0;
        end else begin
            mdl_age <= mdl_age + 1;
        end
    end

    logic exp_req, exp_gnt_any, exp_rv_any, exp_err_any;
    logic exp_m0_gnt, exp_m1_gnt, exp_m0_rv, exp_m1_rv, exp_m0_err, exp_m1_err;
    logic [DW-1:0] exp_data;

    assign exp_req     = mdl_active && !mdl_granted;
    assign exp_gnt_any = mdl_active && !mdl_granted && mem_gnt_i;
    assign exp_rv_any  = mdl_active && mdl_granted && mem_rvalid_i;
    assign exp_err_any = mdl_active && (TO > 0) && (mdl_age == TO - 1) &&
                         !(mdl_granted ? mem_rvalid_i : mem_gnt_i);
    assign exp_m0_gnt  = exp_gnt_any && !mdl_owner;
    assign exp_m1_gnt  = exp_gnt_any &&  mdl_owner;
    assign exp_m0_rv   = exp_rv_any  && !mdl_owner;
    assign exp_m1_rv   = exp_rv_any  &&  mdl_owner;
    assign exp_m0_err  = exp_err_any && !mdl_owner;
    assign exp_m1_err  = exp_err_any &&  mdl_owner;
    assign exp_data    = mem_array[mdl_addr];

    // Per-cycle comparison of every DUT output against the model, sampled
    // on the falling edge when all inputs have settled.
    always @(negedge clk) begin
        checkOutput("mem_req_o",   mem_req_o,   exp_req);
        checkOutput("mem_addr_o",  mem_addr_o,  mdl_addr);
        checkOutput("busy_o",      busy_o,      mdl_active);
        checkOutput("m0_gnt_o",    m0_gnt_o,    exp_m0_gnt);
        checkOutput("m1_gnt_o",    m1_gnt_o,    exp_m1_gnt);
        checkOutput("m0_rvalid_o", m0_rvalid_o, exp_m0_rv);
        checkOutput("m1_rvalid_o", m1_rvalid_o, exp_m1_rv);
        checkOutput("m0_err_o",    m0_err_o,    exp_m0_err);
        checkOutput("m1_err_o",    m1_err_o,    exp_m1_err);
        if (exp_m0_rv) checkOutput("m0_rdata_o", m0_rdata_o, exp_data);
        if (exp_m1_rv) checkOutput("m1_rdata_o", m1_rdata_o, exp_data);
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout at t=%0t: simulation did not finish", $time);
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        bit order [16];
        int n_g;
        int cnt0;
        int cnt1;
        int rv_pulses;

        rst_n        = 1'b0;
        gnt_enable   = 1'b1;
        sticky       = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) mem_array[i] = 32'hC0DE0000 | i;
        mem_array[8'h00] = 32'h00D00113;
        mem_array[8'h04] = 32'h00900093;
        mem_array[8'h08] = 32'h401101B3;

        // Reset values
        @(negedge clk);
        checkOutput("rst_mem_req", mem_req_o, 1'b0);
        checkOutput("rst_mem_addr", mem_addr_o, 8'h00);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_m0_gnt", m0_gnt_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single m0 fetch from 0x04
        $display("[TB] single m0 fetch");
        applyStimulus(1'b1, 8'h04, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("t1_c1_mem_req", mem_req_o, 1'b1);
        checkOutput("t1_c1_mem_addr", mem_addr_o, 8'h04);
        checkOutput("t1_c1_m0_gnt", m0_gnt_o, 1'b0);
        @(negedge clk);
        checkOutput("t1_c2_m0_gnt", m0_gnt_o, 1'b1);
        checkOutput("t1_c2_m1_gnt", m1_gnt_o, 1'b0);
        applyStimulus(1'b0, 8'h04, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("t1_c3_m0_rvalid", m0_rvalid_o, 1'b1);
        checkOutput("t1_c3_m0_rdata", m0_rdata_o, 32'h00900093);
        checkOutput("t1_c3_m1_rvalid", m1_rvalid_o, 1'b0);
        checkOutput("t1_c3_mem_req", mem_req_o, 1'b0);
        @(negedge clk);
        checkOutput("t1_c4_busy", busy_o, 1'b0);

        // Simultaneous requests straight after reset: m0 first, then m1
        $display("[TB] simultaneous after reset");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h00, 1'b1, 8'h08);
        @(negedge clk);
        checkOutput("t2_c1_mem_addr", mem_addr_o, 8'h00);
        @(negedge clk);
        checkOutput("t2_c2_m0_gnt", m0_gnt_o, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h08);
        @(negedge clk);
        checkOutput("t2_c3_m0_rdata", m0_rdata_o, 32'h00D00113);
        @(negedge clk);
        checkOutput("t2_c4_busy", busy_o, 1'b0);
        @(negedge clk);
        checkOutput("t2_c5_mem_req", mem_req_o, 1'b1);
        checkOutput("t2_c5_mem_addr", mem_addr_o, 8'h08);
        @(negedge clk);
        checkOutput("t2_c6_m1_gnt", m1_gnt_o, 1'b1);
        checkOutput("t2_c6_m0_gnt", m0_gnt_o, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h08);
        @(negedge clk);
        checkOutput("t2_c7_m1_rvalid", m1_rvalid_o, 1'b1);
        checkOutput("t2_c7_m1_rdata", m1_rdata_o, 32'h401101B3);
        @(negedge clk);
        checkOutput("t2_c8_busy", busy_o, 1'b0);

        // Both requesting continuously for 8 transactions: strict alternation
        $display("[TB] round-robin alternation");
        n_g = 0;
        cnt0 = 0;
        cnt1 = 0;
        applyStimulus(1'b1, 8'h10, 1'b1, 8'h14);
        for (int k = 0; k < 100 && n_g < 8; k++) begin
            @(negedge clk);
            if (m0_gnt_o && n_g < 16) begin order[n_g] = 1'b0; n_g++; cnt0++; end
            if (m1_gnt_o && n_g < 16) begin order[n_g] = 1'b1; n_g++; cnt1++; end
            if (n_g >= 8) applyStimulus(1'b0, 8'h10, 1'b0, 8'h14);
        end
        if (n_g < 8) begin
            reportTimeout("rr_grants");
            applyStimulus(1'b0, 8'h10, 1'b0, 8'h14);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < n_g) checkOutput($sformatf("rr_order_%0d", i), order[i], i % 2);
        end
        checkOutput("rr_m0_count", cnt0, 4);
        checkOutput("rr_m1_count", cnt1, 4);
        repeat (3) @(negedge clk);
        checkOutput("rr_idle", busy_o, 1'b0);

        // Stale rvalid held high across m1's WAIT_GNT
        $display("[TB] stale rvalid");
        sticky = 1'b1;
        applyStimulus(1'b1, 8'h04, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_c2_m0_gnt", m0_gnt_o, 1'b1);
        applyStimulus(1'b0, 8'h04, 1'b1, 8'h08);
        @(negedge clk);
        checkOutput("t4_c3_m0_rvalid", m0_rvalid_o, 1'b1);
        rv_pulses = 0;
        for (int c = 4; c <= 10; c++) begin
            @(negedge clk);
            if (m1_rvalid_o) rv_pulses++;
            if (c == 5) begin
                checkOutput("t4_c5_mem_req", mem_req_o, 1'b1);
                checkOutput("t4_c5_m1_rvalid", m1_rvalid_o, 1'b0);
            end
            if (c == 6) begin
                checkOutput("t4_c6_m1_gnt", m1_gnt_o, 1'b1);
                applyStimulus(1'b0, 8'h04, 1'b0, 8'h08);
            end
            if (c == 7) checkOutput("t4_c7_m1_rdata", m1_rdata_o, 32'h401101B3);
        end
        checkOutput("t4_m1_rvalid_pulses", rv_pulses, 1);
        sticky = 1'b0;
        repeat (2) @(negedge clk);

        // Watchdog: memory never grants
        $display("[TB] watchdog abort");
        gnt_enable = 1'b0;
        applyStimulus(1'b1, 8'h20, 1'b0, 8'h00);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1)  checkOutput("t5_c1_mem_req", mem_req_o, 1'b1);
            if (c == 15) checkOutput("t5_c15_m0_err", m0_err_o, 1'b0);
            if (c == 16) begin
                checkOutput("t5_c16_m0_err", m0_err_o, 1'b1);
                checkOutput("t5_c16_m1_err", m1_err_o, 1'b0);
                checkOutput("t5_c16_mem_req", mem_req_o, 1'b1);
            end
            if (c == 17) begin
                checkOutput("t5_c17_mem_req", mem_req_o, 1'b0);
                checkOutput("t5_c17_busy", busy_o, 1'b0);
                checkOutput("t5_c17_m0_err", m0_err_o, 1'b0);
            end
            if (c == 18) begin
                checkOutput("t5_c18_mem_req", mem_req_o, 1'b1);
                gnt_enable = 1'b1;
            end
            if (c == 19) begin
                checkOutput("t5_c19_m0_gnt", m0_gnt_o, 1'b1);
                applyStimulus(1'b0, 8'h20, 1'b0, 8'h00);
            end
            if (c == 20) checkOutput("t5_c20_m0_rdata", m0_rdata_o, 32'hC0DE0020);
        end
        @(negedge clk);

        // Reset during WAIT_RVALID, then tie resolved m0 first
        $display("[TB] reset in WAIT_RVALID");
        sticky = 1'b1;
        applyStimulus(1'b1, 8'h04, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 8'h04, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("t6_c3_m0_rvalid", m0_rvalid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_busy", busy_o, 1'b0);
        checkOutput("t6_rst_m0_rvalid", m0_rvalid_o, 1'b0);
        checkOutput("t6_rst_mem_req", mem_req_o, 1'b0);
        sticky = 1'b0;
        applyStimulus(1'b1, 8'h00, 1'b1, 8'h08);
        @(negedge clk);
        rst_n = 1'b1;
        n_g = 0;
        for (int k = 0; k < 40 && n_g < 2; k++) begin
            @(negedge clk);
            if (m0_gnt_o && n_g < 16) begin
                order[n_g] = 1'b0;
                n_g++;
                m0_req_i = 1'b0;
            end
            if (m1_gnt_o && n_g < 16) begin
                order[n_g] = 1'b1;
                n_g++;
                m1_req_i = 1'b0;
            end
        end
        if (n_g < 2) begin
            reportTimeout("t6_grants");
            applyStimulus(1'b0, 8'h00, 1'b0, 8'h08);
        end
        if (n_g >= 1) checkOutput("t6_first_grant", order[0], 1'b0);
        if (n_g >= 2) checkOutput("t6_second_grant", order[1], 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("t6_idle", busy_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
